// File: rtl/dmem_arbiter.sv
`timescale 1ns/1ps
// Two-port round-robin arbiter in front of the data memory.
// Port 0 is the CPU and port 1 a loader/DMA master; one access is in flight at a time.
//
// state  | meaning
// IDLE   | waiting for a request, picks a grant
// ACCESS | memory driven from the granted port (1 cycle write, LATENCY cycles read)
// DONE   | one-cycle ack to the granted port
module dmem_arbiter #(
    parameter int WIDTH   = 32,
    parameter int LATENCY = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0,
    input  logic             we0,
    input  logic [WIDTH-1:0] adr0,
    input  logic [WIDTH-1:0] wd0,
    output logic [WIDTH-1:0] rd0,
    output logic             ack0,
    input  logic             req1,
    input  logic             we1,
    input  logic [WIDTH-1:0] adr1,
    input  logic [WIDTH-1:0] wd1,
    output logic [WIDTH-1:0] rd1,
    output logic             ack1,
    output logic             mem_we,
    output logic [WIDTH-1:0] mem_adr,
    output logic [WIDTH-1:0] mem_wd,
    input  logic [WIDTH-1:0] mem_rd,
    output logic             busy
);

    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic          grant;
    logic          last_grant;
    logic          gnt_we;
    logic [CW-1:0] cnt;
    logic          pick;
    logic          pick_we;

    // On a tie the port that did not win last time goes next.
    assign pick    = (req0 && req1) ? ~last_grant : req1;
    assign pick_we = pick ? we1 : we0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (req0 || req1) state_nxt = ACCESS;
            ACCESS:  if (gnt_we || cnt == '0) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy    = (state != IDLE);
        mem_we  = 1'b0;
        mem_adr = '0;
        mem_wd  = '0;
        ack0    = 1'b0;
        ack1    = 1'b0;
        unique case (state)
            ACCESS: begin
                mem_we  = gnt_we;
                mem_adr = grant ? adr1 : adr0;
                mem_wd  = grant ? wd1 : wd0;
            end
            DONE: begin
                ack0 = ~grant;
                ack1 = grant;
            end
            default: ;
        endcase
    end

    // Grant bookkeeping, read-latency countdown and read-data capture.
    // The direction is latched at grant so a misbehaving requester cannot change it mid-access.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            grant      <= 1'b0;
            last_grant <= 1'b1;
            gnt_we     <= 1'b0;
            cnt        <= '0;
            rd0        <= '0;
            rd1        <= '0;
        end else if (state == IDLE && (req0 || req1)) begin
            grant      <= pick;
            last_grant <= pick;
            gnt_we     <= pick_we;
            cnt        <= pick_we ? '0 : CW'(LATENCY - 1);
        end else if (state == ACCESS && !gnt_we) begin
            if (cnt == '0) begin
                if (grant) rd1 <= mem_rd;
                else       rd0 <= mem_rd;
            end else begin
                cnt <= cnt - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
`timescale 1ns/1ps
// Bench for dmem_arbiter: a LATENCY=2 instance (a) and a LATENCY=1 instance (b), checked
// every cycle against a transaction-timeline model plus directed literal checks.
module tb_dmem_arbiter;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic        a_req0 = 0, a_we0 = 0, a_req1 = 0, a_we1 = 0;
    logic [31:0] a_adr0 = 0, a_wd0 = 0, a_adr1 = 0, a_wd1 = 0;
    logic [31:0] a_rd0, a_rd1, a_mem_adr, a_mem_wd, a_mem_rd;
    logic        a_ack0, a_ack1, a_mem_we, a_busy;

    logic        b_req0 = 0, b_we0 = 0, b_req1 = 0, b_we1 = 0;
    logic [31:0] b_adr0 = 0, b_wd0 = 0, b_adr1 = 0, b_wd1 = 0;
    logic [31:0] b_rd0, b_rd1, b_mem_adr, b_mem_wd, b_mem_rd;
    logic        b_ack0, b_ack1, b_mem_we, b_busy;

    dmem_arbiter #(.WIDTH(32), .LATENCY(2)) u_dut_a (
        .clk(clk), .reset(reset),
        .req0(a_req0), .we0(a_we0), .adr0(a_adr0), .wd0(a_wd0), .rd0(a_rd0), .ack0(a_ack0),
        .req1(a_req1), .we1(a_we1), .adr1(a_adr1), .wd1(a_wd1), .rd1(a_rd1), .ack1(a_ack1),
        .mem_we(a_mem_we), .mem_adr(a_mem_adr), .mem_wd(a_mem_wd), .mem_rd(a_mem_rd),
        .busy(a_busy)
    );

    dmem_arbiter #(.WIDTH(32), .LATENCY(1)) u_dut_b (
        .clk(clk), .reset(reset),
        .req0(b_req0), .we0(b_we0), .adr0(b_adr0), .wd0(b_wd0), .rd0(b_rd0), .ack0(b_ack0),
        .req1(b_req1), .we1(b_we1), .adr1(b_adr1), .wd1(b_wd1), .rd1(b_rd1), .ack1(b_ack1),
        .mem_we(b_mem_we), .mem_adr(b_mem_adr), .mem_wd(b_mem_wd), .mem_rd(b_mem_rd),
        .busy(b_busy)
    );

    function automatic logic [31:0] mem_val(input logic [31:0] adr);
        if (adr == 32'h60) return 32'hDEADBEEF;
        return {adr[15:0], ~adr[15:0]};
    endfunction

    // Memory returns poison until the address has been presented for LATENCY cycles.
    int a_bcnt = 0, b_bcnt = 0;
    always @(posedge clk) begin
        a_bcnt <= a_busy ? a_bcnt + 1 : 0;
        b_bcnt <= b_busy ? b_bcnt + 1 : 0;
    end
    assign a_mem_rd = (a_busy && a_bcnt >= 1) ? mem_val(a_mem_adr) : 32'hBAD0BAD0;
    assign b_mem_rd = b_busy ? mem_val(b_mem_adr) : 32'hBAD0BAD0;

    int total = 0;
    int bad = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: a transaction is a timeline of len cycles; cycles 1..len-1 drive memory, cycle len acks.
    typedef struct {
        int          phase;
        int          len;
        logic        g;
        logic        we;
        logic        lastg;
        logic [31:0] rd0;
        logic [31:0] rd1;
    } mdl_t;

    function automatic mdl_t mdl_reset();
        mdl_t m;
        m.phase = 0; m.len = 0; m.g = 0; m.we = 0; m.lastg = 1; m.rd0 = 0; m.rd1 = 0;
        return m;
    endfunction

    function automatic mdl_t mdl_step(input mdl_t m, input int lat, input logic r0, input logic r1,
                                      input logic w0, input logic w1,
                                      input logic [31:0] ad0, input logic [31:0] ad1);
        mdl_t n = m;
        if (m.phase == 0) begin
            if (r0 || r1) begin
                n.g     = (r0 && r1) ? !m.lastg : r1;
                n.lastg = n.g;
                n.we    = n.g ? w1 : w0;
                n.len   = n.we ? 2 : lat + 1;
                n.phase = 1;
            end
        end else if (m.phase == m.len) begin
            n.phase = 0;
        end else begin
            if (!m.we && m.phase == m.len - 1) begin
                if (m.g) n.rd1 = mem_val(ad1);
                else     n.rd0 = mem_val(ad0);
            end
            n.phase = m.phase + 1;
        end
        return n;
    endfunction

    mdl_t ma, mb;
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            ma <= mdl_reset();
            mb <= mdl_reset();
        end else begin
            ma <= mdl_step(ma, 2, a_req0, a_req1, a_we0, a_we1, a_adr0, a_adr1);
            mb <= mdl_step(mb, 1, b_req0, b_req1, b_we0, b_we1, b_adr0, b_adr1);
        end
    end

    task automatic cmp_inst(input string p, input mdl_t m,
                            input logic ack0, input logic ack1, input logic we, input logic bsy,
                            input logic [31:0] madr, input logic [31:0] mwd,
                            input logic [31:0] rd0, input logic [31:0] rd1,
                            input logic [31:0] ad0, input logic [31:0] ad1,
                            input logic [31:0] wd0, input logic [31:0] wd1);
        logic act = (m.phase != 0) && (m.phase < m.len);
        logic fin = (m.phase != 0) && (m.phase == m.len);
        check($sformatf("%s.busy", p), 32'(bsy), 32'(m.phase != 0));
        check($sformatf("%s.ack0", p), 32'(ack0), 32'(fin && !m.g));
        check($sformatf("%s.ack1", p), 32'(ack1), 32'(fin && m.g));
        check($sformatf("%s.mem_we", p), 32'(we), 32'(act && m.we));
        check($sformatf("%s.mem_adr", p), madr, act ? (m.g ? ad1 : ad0) : 32'h0);
        check($sformatf("%s.mem_wd", p), mwd, act ? (m.g ? wd1 : wd0) : 32'h0);
        check($sformatf("%s.rd0", p), rd0, m.rd0);
        check($sformatf("%s.rd1", p), rd1, m.rd1);
    endtask

    logic chk_en = 1'b0;
    always @(negedge clk) begin
        if (chk_en) begin
            cmp_inst("a", ma, a_ack0, a_ack1, a_mem_we, a_busy, a_mem_adr, a_mem_wd,
                     a_rd0, a_rd1, a_adr0, a_adr1, a_wd0, a_wd1);
            cmp_inst("b", mb, b_ack0, b_ack1, b_mem_we, b_busy, b_mem_adr, b_mem_wd,
                     b_rd0, b_rd1, b_adr0, b_adr1, b_wd0, b_wd1);
        end
    end

    // Cumulative event counters for instance a; tests work on differences.
    int a_we_n = 0, a_ack0_n = 0, a_ack1_n = 0, a_both_n = 0, a_adr60_n = 0;
    logic [31:0] a_wadr = 0, a_wdat = 0;
    int a_order[$];
    always @(negedge clk) begin
        if (a_mem_we) begin
            a_we_n <= a_we_n + 1;
            a_wadr <= a_mem_adr;
            a_wdat <= a_mem_wd;
        end
        if (a_ack0) begin a_ack0_n <= a_ack0_n + 1; a_order.push_back(0); end
        if (a_ack1) begin a_ack1_n <= a_ack1_n + 1; a_order.push_back(1); end
        if (a_ack0 && a_ack1) a_both_n <= a_both_n + 1;
        if (a_busy && a_mem_adr == 32'h60) a_adr60_n <= a_adr60_n + 1;
    end

    task automatic drive(input int inst, input int p, input logic rq, input logic we,
                         input logic [31:0] adr, input logic [31:0] wd);
        case ({inst[0], p[0]})
            2'b00: begin a_req0 = rq; a_we0 = we; a_adr0 = adr; a_wd0 = wd; end
            2'b01: begin a_req1 = rq; a_we1 = we; a_adr1 = adr; a_wd1 = wd; end
            2'b10: begin b_req0 = rq; b_we0 = we; b_adr0 = adr; b_wd0 = wd; end
            default: begin b_req1 = rq; b_we1 = we; b_adr1 = adr; b_wd1 = wd; end
        endcase
    endtask

    function automatic logic ack_of(input int inst, input int p);
        case ({inst[0], p[0]})
            2'b00:   return a_ack0;
            2'b01:   return a_ack1;
            2'b10:   return b_ack0;
            default: return b_ack1;
        endcase
    endfunction

    // One handshake; lat is the number of falling edges from req assertion to ack.
    task automatic txn(input int inst, input int p, input logic we, input logic [31:0] adr,
                       input logic [31:0] wd, output int lat);
        bit done = 0;
        @(posedge clk); #1;
        drive(inst, p, 1'b1, we, adr, wd);
        lat = 0;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            lat++;
            if (ack_of(inst, p)) done = 1;
        end
        check("txn_ack_seen", 32'(done), 1);
        @(posedge clk); #1;
        drive(inst, p, 1'b0, we, adr, wd);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, total=%0d", total);
        $fatal(1);
    end

    initial begin
        int lat, lat0, lat1, base0, base1, base2, obase, n;
        bit done;

        #1 reset = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        check("rst_busy", 32'(a_busy), 0);
        check("rst_mem_we", 32'(a_mem_we), 0);
        check("rst_ack", 32'({a_ack0, a_ack1, b_ack0, b_ack1}), 0);
        check("rst_rd1", a_rd1, 0);
        @(posedge clk); #1;
        reset = 1'b1;
        chk_en = 1'b1;

        // Port 0 write
        base0 = a_we_n; base1 = a_ack1_n;
        txn(0, 0, 1'b1, 32'h64, 32'h7, lat);
        check("wr_latency", lat - 1, 2);
        check("wr_we_pulses", a_we_n - base0, 1);
        check("wr_mem_adr", a_wadr, 32'h64);
        check("wr_mem_wd", a_wdat, 32'h7);
        check("wr_ack1_quiet", a_ack1_n - base1, 0);

        // Port 1 read, LATENCY=2
        base0 = a_adr60_n;
        txn(0, 1, 1'b0, 32'h60, 32'h0, lat);
        check("rd_latency", lat - 1, 3);
        check("rd_adr_cycles", a_adr60_n - base0, 2);
        check("rd_rd1", a_rd1, 32'hDEADBEEF);
        check("rd_rd0_kept", a_rd0, 32'h0);

        // Simultaneous writes: port 0 first
        obase = a_order.size();
        fork
            txn(0, 0, 1'b1, 32'h10, 32'h11, lat0);
            txn(0, 1, 1'b1, 32'h14, 32'h22, lat1);
        join
        check("tie_first", 32'(a_order[obase]), 0);
        check("tie_second", 32'(a_order[obase + 1]), 1);
        check("tie_lat0", lat0 - 1, 2);

        // Both held: strict alternation for six transactions
        obase = a_order.size(); base0 = a_ack0_n; base1 = a_ack1_n;
        @(posedge clk); #1;
        drive(0, 0, 1'b1, 1'b1, 32'h20, 32'h55);
        drive(0, 1, 1'b1, 1'b0, 32'h60, 32'h0);
        n = 0;
        for (int i = 0; i < 60 && n < 6; i++) begin
            @(negedge clk);
            if (a_ack0) n++;
            if (a_ack1) n++;
        end
        check("rr_six_acks", n, 6);
        @(posedge clk); #1;
        drive(0, 0, 1'b0, 1'b1, 32'h20, 32'h55);
        drive(0, 1, 1'b0, 1'b0, 32'h60, 32'h0);
        #1;
        for (int i = 0; i < 6; i++)
            check($sformatf("rr_order%0d", i), 32'(a_order[obase + i]), i % 2);
        check("rr_ack0_cnt", a_ack0_n - base0, 3);
        check("rr_ack1_cnt", a_ack1_n - base1, 3);
        check("no_ack_overlap", a_both_n, 0);

        // Reset during the second ACCESS cycle of a read
        base0 = a_ack0_n; base1 = a_ack1_n;
        @(posedge clk); #1;
        drive(0, 1, 1'b1, 1'b0, 32'h60, 32'h0);
        @(posedge clk);
        @(posedge clk);
        #3 reset = 1'b0;
        #1;
        check("arst_mem_we", 32'(a_mem_we), 0);
        check("arst_busy", 32'(a_busy), 0);
        check("arst_mem_adr", a_mem_adr, 32'h0);
        check("arst_rd1", a_rd1, 32'h0);
        drive(0, 1, 1'b0, 1'b0, 32'h60, 32'h0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        check("arst_no_ack", (a_ack0_n - base0) + (a_ack1_n - base1), 0);
        txn(0, 0, 1'b0, 32'h60, 32'h0, lat);
        check("arst_after_lat", lat - 1, 3);
        check("arst_after_rd0", a_rd0, 32'hDEADBEEF);

        // LATENCY=1: back-to-back port 0 reads with one IDLE between
        @(posedge clk); #1;
        drive(1, 0, 1'b1, 1'b0, 32'h0, 32'h0);
        n = 0; done = 0;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk); n++;
            if (b_ack0) done = 1;
        end
        check("l1_lat0", n - 1, 2);
        check("l1_rd0_a", b_rd0, 32'h0000FFFF);
        @(posedge clk); #1;
        drive(1, 0, 1'b1, 1'b0, 32'h4, 32'h0);
        n = 0; done = 0;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk); n++;
            if (b_ack0) done = 1;
        end
        check("l1_gap", n, 3);
        check("l1_rd0_b", b_rd0, 32'h0004FFFB);
        @(posedge clk); #1;
        drive(1, 0, 1'b0, 1'b0, 32'h4, 32'h0);

        repeat (3) @(posedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Two-port arbiter that shares the single data memory between the processor (port 0) and a second bus master such as a program loader or DMA engine (port 1). Each requester uses a req/ack handshake. The arbiter grants one requester at a time using round-robin priority, sequences the memory access over a configurable read latency, and returns read data with a one-cycle ack. It sits between the core's memory interface and the data memory inside top.

Parameters:
WIDTH, 32, data and address width in bits
LATENCY, 2, memory read latency in cycles; must be >= 1 (0 is illegal)

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-low reset
req0  input  1  port 0 (CPU) request
we0  input  1  port 0 write enable (1 = write, 0 = read)
adr0  input  WIDTH  port 0 byte address
wd0  input  WIDTH  port 0 write data
rd0  output  WIDTH  port 0 read data
ack0  output  1  port 0 transaction complete, one-cycle pulse
req1, we1, adr1, wd1, rd1, ack1  same as port 0, for port 1
mem_we  output  1  memory write strobe
mem_adr  output  WIDTH  memory address
mem_wd  output  WIDTH  memory write data
mem_rd  input  WIDTH  memory read data, valid LATENCY cycles after mem_adr is presented
busy  output  1  high while a transaction is in progress

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; last_grant=1, so port 0 wins the first tie. All outputs go to 0: ack0/1, rd0/1, mem_we, mem_adr, mem_wd, busy.
- FSM states are IDLE, ACCESS, DONE.
- IDLE:
  - If no req is high, stay in IDLE.
  - If exactly one req is high, register that port as grant.
  - If both are high, grant the port != last_grant.
  - On a grant, set last_grant=grant, set cnt = (granted we ? 0 : LATENCY-1), and go to ACCESS.
- ACCESS:
  - mem_adr and mem_wd come combinationally from the granted port's adr/wd.
  - Write: mem_we=1 for exactly this one cycle, then go to DONE.
  - Read: mem_we=0. Stay LATENCY cycles, decrementing cnt. In the cycle where cnt==0, capture mem_rd into rd of the granted port, then go to DONE.
- DONE:
  - ack of the granted port = 1 for exactly one cycle; the other ack stays 0.
  - mem_adr, mem_wd and mem_we are 0.
  - Next state is IDLE.
- Outside ACCESS, mem_adr, mem_wd and mem_we are 0.
- busy=1 in ACCESS and DONE, 0 in IDLE.
- Latency from req sampled in IDLE to ack: write = 2 cycles; read = LATENCY+1 cycles. Minimum spacing between transactions is 3 cycles (write) or LATENCY+2 cycles (read).
- rdN holds its last captured value until the next read completes on that port. Writes never change rd0/rd1.
- Requester rules:
  - Hold we, adr and wd stable from req assertion until ack.
  - Deassert req in the cycle after ack. A req still high in the following IDLE is treated as a new transaction.
- req dropped before ack is a protocol violation. The arbiter still completes the access and pulses ack; inputs are not re-sampled.
- Fairness: with both req held continuously, grants strictly alternate 0,1,0,1.
- Reset mid-transaction: immediately return to IDLE and force mem_we=0. No ack is issued for the aborted access. rd0/1 clear to 0.

Test Plan:
- Port 0 write, adr0=0x64, wd0=7, req1=0 -> mem_we=1 for one cycle with mem_adr=0x64 and mem_wd=7; ack0 pulses 2 cycles after req sampled; ack1 stays 0.
- Port 1 read, adr1=0x60, LATENCY=2, memory returns 0xDEADBEEF -> mem_adr=0x60 for 2 cycles; rd1=0xDEADBEEF when ack1 pulses 3 cycles after req sampled; rd0 unchanged.
- req0 and req1 rise in the same cycle after reset, both writes -> port 0 is served first, then port 1; acks never overlap; last_grant ends at 1.
- req0 and req1 held high for 6 transactions -> grant order is 0,1,0,1,0,1; each port gets exactly 3 acks.
- reset driven low during the second ACCESS cycle of a read -> mem_we, busy and mem_adr go to 0 without waiting for a clock edge; no ack pulses; after reset release, the next request completes normally.
- LATENCY=1 build, back-to-back port 0 reads of 0x00 then 0x04 -> each ack arrives 2 cycles after its req sample, separated by one IDLE cycle; rd0 shows the correct data for each read.
